// File: rtl/axi_lite_rr_arbiter_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter.
// FSM state encoding and AXI response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI4-Lite bus bundle between arbiter and interconnect.
// master = arbiter side, slave = interconnect side.
interface axi_lite_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR,
    output WVALID, WDATA, WSTRB,
    output BREADY,
    output ARVALID, ARADDR,
    output RREADY,
    input  AWREADY, WREADY,
    input  BVALID, BRESP,
    input  ARREADY,
    input  RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR,
    input  WVALID, WDATA, WSTRB,
    input  BREADY,
    input  ARVALID, ARADDR,
    input  RREADY,
    output AWREADY, WREADY,
    output BVALID, BRESP,
    output ARREADY,
    output RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi_lite_rr_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
// Searches from last+1 upward, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // first set request after the pointer wins
  always_comb begin
    int j;
    logic [IDX_W-1:0] w_j;
    j     = 0;
    w_j   = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j   = (int'(i_last) + k) % NUM_REQ;
      w_j = IDX_W'(j);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port.
// One transaction in flight; 1-cycle response pulse.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  axi_lite_rr_arbiter_if.master        m_axi
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_W / 8;

  state_t              r_state;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_grant_id;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;

  logic                r_awvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_bready;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_rready;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_wstrb;
  logic                w_aw_done;
  logic                w_w_done;
  logic [NUM_REQ-1:0]  w_rsp_hot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_sel_addr  = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = req_wdata[w_idx*DATA_W +: DATA_W];
  assign w_sel_wstrb = req_wstrb[w_idx*STRB_W +: STRB_W];

  assign w_aw_done = !r_awvalid || m_axi.AWREADY;
  assign w_w_done  = !r_wvalid || m_axi.WREADY;
  assign w_rsp_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

  assign req_ready = (ARESETn && r_state == IDLE) ? w_gnt : '0;
  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grant_id;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

  assign m_axi.AWVALID = r_awvalid;
  assign m_axi.AWADDR  = r_awaddr;
  assign m_axi.WVALID  = r_wvalid;
  assign m_axi.WDATA   = r_wdata;
  assign m_axi.WSTRB   = r_wstrb;
  assign m_axi.BREADY  = r_bready;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.ARADDR  = r_araddr;
  assign m_axi.RREADY  = r_rready;

  // transaction sequencer with registered bus outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last     <= w_idx;
            r_grant_id <= w_idx;
            if (req_write[w_idx]) begin
              r_state   <= WR_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_sel_addr;
              r_wdata   <= w_sel_wdata;
              r_wstrb   <= w_sel_wstrb;
            end else begin
              r_state   <= RD_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_sel_addr;
            end
          end
        end
        WR_AW_W: begin
          if (m_axi.AWREADY) r_awvalid <= 1'b0;
          if (m_axi.WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi.BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= w_rsp_hot;
            r_rsp_resp  <= m_axi.BRESP;
            r_state     <= IDLE;
          end
        end
        RD_AR: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi.RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= w_rsp_hot;
            r_rsp_rdata <= m_axi.RDATA;
            r_rsp_resp  <= m_axi.RRESP;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter.
// Scoreboard of expected responses plus a delay-programmable slave.
module tb_axi_lite_rr_arbiter;
  import axi_lite_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_write = '0;
  logic [N*AW-1:0]     req_addr  = '0;
  logic [N*DW-1:0]     req_wdata = '0;
  logic [N*DW/8-1:0]   req_wstrb = '0;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic [1:0]          rsp_resp;
  logic                busy;
  logic [1:0]          grant_id;

  axi_lite_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ax ();

  axi_lite_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
    .grant_id  (grant_id),
    .m_axi     (ax)
  );

  // slave model: each ready/valid rises after a programmable wait
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c, w_c, b_c, ar_c, r_c;
  logic [1:0]  bresp_v = RESP_OKAY;
  logic [1:0]  rresp_v = RESP_OKAY;
  logic [31:0] rdata_v = 32'hCAFEF00D;

  assign ax.AWREADY = ax.AWVALID && (aw_c >= aw_dly);
  assign ax.WREADY  = ax.WVALID  && (w_c  >= w_dly);
  assign ax.BVALID  = ax.BREADY  && (b_c  >= b_dly);
  assign ax.ARREADY = ax.ARVALID && (ar_c >= ar_dly);
  assign ax.RVALID  = ax.RREADY  && (r_c  >= r_dly);
  assign ax.BRESP   = bresp_v;
  assign ax.RRESP   = rresp_v;
  assign ax.RDATA   = rdata_v;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
    end else begin
      aw_c <= (ax.AWVALID && !ax.AWREADY) ? aw_c + 1 : 0;
      w_c  <= (ax.WVALID  && !ax.WREADY)  ? w_c + 1  : 0;
      b_c  <= (ax.BREADY  && !ax.BVALID)  ? b_c + 1  : 0;
      ar_c <= (ax.ARVALID && !ax.ARREADY) ? ar_c + 1 : 0;
      r_c  <= (ax.RREADY  && !ax.RVALID)  ? r_c + 1  : 0;
    end
  end

  typedef struct {
    logic [N-1:0] hot;
    logic         wr;
    logic [31:0]  rdata;
    logic [1:0]   resp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int id, input bit wr,
                               input logic [31:0] rd, input logic [1:0] rs);
    exp_t e;
    e.hot   = N'(1) << id;
    e.wr    = wr;
    e.rdata = rd;
    e.resp  = rs;
    sb.push_back(e);
  endfunction

  // drive one command, wait for accept, check the bus at T+1
  task automatic issue(input int id, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
    req_wstrb[id*4 +: 4]   = s;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[id]) begin got = 1; break; end
      @(negedge ACLK);
    end
    chk("accept", got, 1);
    if (got) begin
      chk("ready_onehot", req_ready, 1 << id);
      @(posedge ACLK);
      @(negedge ACLK);
      chk("grant_id", grant_id, id);
      chk("busy", busy, 1);
      if (wr) begin
        chk("awvalid_t1", ax.AWVALID, 1);
        chk("wvalid_t1", ax.WVALID, 1);
        chk("awaddr", ax.AWADDR, a);
        chk("wdata", ax.WDATA, d);
        chk("wstrb", ax.WSTRB, s);
      end else begin
        chk("arvalid_t1", ax.ARVALID, 1);
        chk("araddr", ax.ARADDR, a);
      end
    end
    req_valid[id] = 1'b0;
  endtask

  // wait for a response pulse and compare against the scoreboard head
  task automatic wait_rsp(input string tag);
    bit got = 0;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      if (|rsp_valid) begin got = 1; break; end
      @(negedge ACLK);
    end
    chk({tag, "_seen"}, got, 1);
    if (got) begin
      chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_rsp_valid"}, rsp_valid, e.hot);
        chk({tag, "_rsp_resp"}, rsp_resp, e.resp);
        chk({tag, "_busy_low"}, busy, 0);
        if (!e.wr) chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    // reset state, with requests present to test req_ready gating
    req_valid = 4'hF;
    @(negedge ACLK);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_awvalid", ax.AWVALID, 0);
    chk("rst_wvalid", ax.WVALID, 0);
    chk("rst_arvalid", ax.ARVALID, 0);
    chk("rst_bready", ax.BREADY, 0);
    chk("rst_rready", ax.RREADY, 0);
    chk("rst_awaddr", ax.AWADDR, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    @(negedge ACLK);
    ARESETn = 1'b1;

    // write fast path
    b_dly = 2;
    push(0, 1, 32'h0, RESP_OKAY);
    issue(0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    @(negedge ACLK);
    chk("fast_awvalid_t2", ax.AWVALID, 0);
    chk("fast_wvalid_t2", ax.WVALID, 0);
    chk("fast_bready", ax.BREADY, 1);
    wait_rsp("fast");
    @(negedge ACLK);
    chk("fast_rsp_pulse_end", rsp_valid, 0);
    b_dly = 0;

    // split AW / W handshakes
    w_dly = 3;
    push(0, 1, 32'h0, RESP_OKAY);
    issue(0, 1, 32'h104, 32'hA5A50001, 4'h3);
    @(negedge ACLK);
    chk("split_aw_drop", ax.AWVALID, 0);
    chk("split_w_hold", ax.WVALID, 1);
    chk("split_wdata", ax.WDATA, 32'hA5A50001);
    chk("split_bready_t2", ax.BREADY, 0);
    @(negedge ACLK);
    chk("split_w_hold3", ax.WVALID, 1);
    chk("split_bready_t3", ax.BREADY, 0);
    @(negedge ACLK);
    chk("split_w_hold4", ax.WVALID, 1);
    chk("split_aw_low4", ax.AWVALID, 0);
    @(negedge ACLK);
    chk("split_w_drop", ax.WVALID, 0);
    chk("split_bready_t5", ax.BREADY, 1);
    wait_rsp("split");
    w_dly = 0;

    // pointer back to NUM_REQ-1 so the rotation starts at 0
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;

    // round robin with all four held valid
    req_valid = 4'hF;
    req_write = 4'h0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
    for (int k = 0; k < 5; k++) push(k % N, 0, rdata_v, RESP_OKAY);
    for (int k = 0; k < 5; k++) begin
      bit got = 0;
      for (int i = 0; i < 60; i++) begin
        #1;
        if (|req_ready) begin got = 1; break; end
        @(negedge ACLK);
      end
      chk("rr_accept", got, 1);
      chk("rr_ready", req_ready, 1 << (k % N));
      @(posedge ACLK);
      @(negedge ACLK);
      chk("rr_grant_id", grant_id, k % N);
      chk("rr_arvalid", ax.ARVALID, 1);
      chk("rr_araddr", ax.ARADDR, 32'h1000 + 32'((k % N) * 16));
      if (k == 4) req_valid = '0;
      wait_rsp("rr");
    end

    // read with SLVERR
    rdata_v = 32'h12345678;
    rresp_v = RESP_SLVERR;
    push(2, 0, 32'h12345678, RESP_SLVERR);
    issue(2, 0, 32'h40, 32'h0, 4'h0);
    wait_rsp("rderr");
    rresp_v = RESP_OKAY;

    // back-to-back: req1 waits behind req0's read
    rdata_v = 32'h0BADF00D;
    r_dly = 2;
    push(0, 0, 32'h0BADF00D, RESP_OKAY);
    issue(0, 0, 32'h200, 32'h0, 4'h0);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1*AW +: AW] = 32'h300;
    push(1, 0, 32'h0BADF00D, RESP_OKAY);
    #1;
    chk("b2b_ready_busy", req_ready, 0);
    wait_rsp("b2b0");
    chk("b2b_ready_with_rsp", req_ready, 4'b0010);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("b2b_arvalid", ax.ARVALID, 1);
    chk("b2b_araddr", ax.ARADDR, 32'h300);
    chk("b2b_grant", grant_id, 1);
    req_valid[1] = 1'b0;
    wait_rsp("b2b1");
    r_dly = 0;

    // reset in the middle of a write
    aw_dly = 5;
    w_dly = 5;
    issue(3, 1, 32'h300, 32'h11112222, 4'hF);
    req_valid = 4'b1001;
    req_write = 4'b1001;
    req_addr[0 +: AW] = 32'h500;
    #3;
    ARESETn = 1'b0;
    #1;
    chk("mrst_awvalid", ax.AWVALID, 0);
    chk("mrst_wvalid", ax.WVALID, 0);
    chk("mrst_awaddr", ax.AWADDR, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_grant_id", grant_id, 0);
    chk("mrst_req_ready", req_ready, 0);
    sb.delete();
    aw_dly = 0;
    w_dly = 0;
    @(negedge ACLK);
    #2;
    ARESETn = 1'b1;
    push(0, 1, 32'h0, RESP_OKAY);
    #1;
    chk("mrst_first_req0", req_ready, 4'b0001);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mrst_grant0", grant_id, 0);
    chk("mrst_awaddr0", ax.AWADDR, 32'h500);
    req_valid = '0;
    wait_rsp("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
Shares one AXI4-Lite master port among NUM_REQ local requesters using round-robin arbitration. Each requester issues single read or write commands over a valid/ready interface and receives a one-cycle response pulse. Only one transaction is in flight at a time. The block sits between the local command sources and the AXI4-Lite interconnect, and sequences the AW/W/B and AR/R channels.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept (one-hot)
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_wstrb  in  NUM_REQ*DATA_W/8  packed strobes
rsp_valid  out  NUM_REQ  one-hot response pulse
rsp_rdata  out  DATA_W  read data, shared by all requesters
rsp_resp  out  2  BRESP or RRESP of the completed transaction
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
AWVALID, AWREADY, AWADDR, WVALID, WREADY, WDATA, WSTRB, BVALID, BREADY, BRESP, ARVALID, ARREADY, ARADDR, RVALID, RREADY, RDATA, RRESP  standard AXI4-Lite master directions and widths

Behaviour:
- Reset: ARESETn is asynchronous and active-low; clock is ACLK.
  - On reset, all registered outputs go to 0 (AW/W/AR valids, BREADY, RREADY, addresses, data, rsp_*, grant_id), state = IDLE, and the RR pointer last = NUM_REQ-1.
  - req_ready is 0 while ARESETn is low.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
- IDLE:
  - req_ready = onehot(g) only when state is IDLE and |req_valid; otherwise 0. req_ready is combinational.
  - g is the first requester with req_valid set, searching from last+1 upward and wrapping modulo NUM_REQ.
  - On accept (cycle T), capture addr/wdata/wstrb/write, set last = g and grant_id = g.
  - Next state is WR_AW_W or RD_AR; the AXI valid(s) go high at T+1.
- WR_AW_W:
  - AWVALID and WVALID are both asserted together.
  - Each deasserts independently on the cycle after its own handshake.
  - AWADDR, WDATA and WSTRB stay stable until their handshake.
  - When both handshakes are done (including the same cycle), go to WR_B with BREADY = 1.
- WR_B: on BVALID & BREADY, BREADY goes to 0, rsp_valid[g] pulses for 1 cycle with rsp_resp = BRESP, then IDLE.
- RD_AR: ARVALID is held until ARREADY, then RD_R with RREADY = 1.
- RD_R: on RVALID & RREADY, rsp_rdata = RDATA and rsp_resp = RRESP, rsp_valid[g] pulses for 1 cycle, then IDLE.
- rsp_rdata/rsp_resp hold their value until the next response.
- rsp_valid is asserted in the cycle after the B/R handshake. state is IDLE in that same cycle, so a new accept may coincide with the rsp_valid pulse. This is legal and required.
- Never more than one outstanding transaction; no AXI valid is asserted outside its state.
- A requester that drops req_valid before grant is simply skipped; there is no penalty.
- A requester that keeps req_valid high after acceptance is treated as a new command.
- Non-OKAY responses are passed through unmodified; no retry.
- Reset mid-transaction:
  - Outputs clear immediately and the transaction is abandoned.
  - The pointer resets, so requester 0 wins first after release.

Decomposition:
- Package axi_lite_pkg holds:
  - state enum (IDLE, WR_AW_W, WR_B, RD_AR, RD_R)
  - RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
- Sub-module rr_arbiter: req vector plus last pointer in, one-hot grant plus index out. Purely combinational; the pointer register stays in the top level.

Test Plan:
- Write fast path: req0 write addr 0x100, data 0xDEADBEEF, strb 0xF; AWREADY = WREADY = 1; BVALID 2 cycles later with OKAY.
  - AWVALID/WVALID high exactly one cycle at T+1; rsp_valid = 4'b0001 one cycle; rsp_resp = 00; busy falls.
- Split AW/W: AWREADY at T+1, WREADY delayed 3 cycles.
  - AWVALID drops at T+2; WVALID held with WDATA stable; BREADY rises only after the W handshake.
- Round-robin: all four req_valid held high with read commands, slave responds each time.
  - Grant order is 0,1,2,3,0; grant_id matches; each rsp_valid is one-hot to the correct requester.
- Read error: req2 read addr 0x40; slave RDATA = 0x12345678, RRESP = 2'b10.
  - rsp_valid = 4'b0100, rsp_rdata = 0x12345678, rsp_resp = 10.
- Back-to-back: req1 waiting while req0's read completes.
  - req_ready[1] is asserted in the same cycle as rsp_valid[0]; ARVALID for req1 rises the next cycle.
- Reset mid-write: ARESETn low while AWVALID = 1.
  - All outputs 0 asynchronously; after release with req0 and req3 both valid, req0 is granted first.
